// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state enum, default sizes and address check for the data memory responder
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 1024;
  localparam int unsigned DMEM_CNT_W = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

  // Word-index check; addresses are used directly, no byte shift.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < 32'(depth);
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// rtl/data_mem_resp_if.sv - core data-port bus between the RISCV core (master) and data memory (slave)
interface data_mem_resp_if;

  logic [31:0] DataMemAddr;
  logic        DataMemRead;
  logic        DataMemWrite;
  logic [31:0] DataMemWData;
  logic [31:0] DataMemRData;

  modport master (
    output DataMemAddr, DataMemRead, DataMemWrite, DataMemWData,
    input  DataMemRData
  );

  modport slave (
    input  DataMemAddr, DataMemRead, DataMemWrite, DataMemWData,
    output DataMemRData
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 32 word storage, one synchronous write port and one asynchronous read port
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_clr_we,
  input  logic [AW-1:0] i_clr_idx,
  input  logic          i_core_we,
  input  logic [AW-1:0] i_core_addr,
  input  logic [31:0]   i_core_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0]   r_mem [DEPTH];
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;

  // The clear sequencer owns the write port whenever it is active.
  assign w_we    = i_clr_we | i_core_we;
  assign w_waddr = i_clr_we ? i_clr_idx : i_core_addr;
  assign w_wdata = i_clr_we ? 32'd0 : i_core_wdata;

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - data-memory responder: storage, clear sequencer, access counters, sticky error capture
// Build option: DMEM_CLEAR_EN compiles in the post-reset CLEAR sequencer.
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned CNT_W = DMEM_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  data_mem_resp_if.slave   bus,
  output logic             MemReady,
  output logic             AccessErr,
  output logic [31:0]      ErrAddr,
  output logic [CNT_W-1:0] RdCount,
  output logic [CNT_W-1:0] WrCount
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic             r_ready;
  logic             r_err;
  logic [31:0]      r_err_addr;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;

  logic             w_ok;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_err;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_idx;
  logic [31:0]      w_rdata;

  assign w_ok     = r_ready && addr_in_range(bus.DataMemAddr, DEPTH);
  assign w_rd_acc = bus.DataMemRead && w_ok;
  assign w_wr_acc = bus.DataMemWrite && w_ok;
  assign w_err    = (bus.DataMemRead || bus.DataMemWrite) && !w_ok;

`ifdef DMEM_CLEAR_EN
  dmem_state_t   r_state;
  logic [AW-1:0] r_clr_idx;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_idx <= r_clr_idx + AW'(1);
          if (r_clr_idx == AW'(DEPTH - 1)) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end
        end
        READY:   r_ready <= 1'b1;
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign w_clr_we  = (r_state == CLEAR);
  assign w_clr_idx = r_clr_idx;
`else
  // No sequencer: accesses are only refused in the first cycle after release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  assign w_clr_we  = 1'b0;
  assign w_clr_idx = '0;
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk        (CLK),
    .i_clr_we     (w_clr_we),
    .i_clr_idx    (w_clr_idx),
    .i_core_we    (w_wr_acc),
    .i_core_addr  (bus.DataMemAddr[AW-1:0]),
    .i_core_wdata (bus.DataMemWData),
    .i_raddr      (bus.DataMemAddr[AW-1:0]),
    .o_rdata      (w_rdata)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      if (w_rd_acc && !(&r_rd_cnt)) begin
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
      if (w_wr_acc && !(&r_wr_cnt)) begin
        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      end
      // ErrAddr keeps the first offender only.
      if (w_err) begin
        r_err <= 1'b1;
        if (!r_err) begin
          r_err_addr <= bus.DataMemAddr;
        end
      end
    end
  end

  assign bus.DataMemRData = w_rd_acc ? w_rdata : 32'd0;
  assign MemReady         = r_ready;
  assign AccessErr        = r_err;
  assign ErrAddr          = r_err_addr;
  assign RdCount          = r_rd_cnt;
  assign WrCount          = r_wr_cnt;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - self-checking bench for data_mem_resp: directed table, corner sequences, random vs model
module tb_data_mem_resp;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned CW    = 8;
  localparam int unsigned CMAX  = (1 << CW) - 1;
`ifdef DMEM_CLEAR_EN
  localparam int unsigned READY_EDGES = DEPTH;
  localparam bit          CLEARS_MEM  = 1'b1;
`else
  localparam int unsigned READY_EDGES = 1;
  localparam bit          CLEARS_MEM  = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          MemReady;
  logic          AccessErr;
  logic [31:0]   ErrAddr;
  logic [CW-1:0] RdCount;
  logic [CW-1:0] WrCount;

  data_mem_resp_if bus ();

  data_mem_resp #(
    .DEPTH (DEPTH),
    .CNT_W (CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .MemReady  (MemReady),
    .AccessErr (AccessErr),
    .ErrAddr   (ErrAddr),
    .RdCount   (RdCount),
    .WrCount   (WrCount)
  );

  initial forever #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sparse word store, edge count since release, plain counters.
  logic [31:0] m_mem [int];
  int unsigned m_edges;
  bit          m_ready;
  bit          m_err;
  logic [31:0] m_ea;
  int unsigned m_rd;
  int unsigned m_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    chk("mem_ready",  {31'd0, MemReady},  {31'd0, m_ready});
    chk("access_err", {31'd0, AccessErr}, {31'd0, m_err});
    chk("err_addr",   ErrAddr,            m_ea);
    chk("rd_count",   32'(RdCount),       m_rd);
    chk("wr_count",   32'(WrCount),       m_wr);
  endtask

  task automatic do_reset();
    RST              = 1'b0;
    bus.DataMemRead  = 1'b1;
    bus.DataMemWrite = 1'b0;
    bus.DataMemAddr  = 32'd0;
    bus.DataMemWData = 32'd0;
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_ea    = 32'd0;
    m_rd    = 0;
    m_wr    = 0;
    m_edges = 0;
    if (CLEARS_MEM) m_mem.delete();
    #2;
    chk("rst_rdata", bus.DataMemRData, 32'd0);
    chk_outputs();
    @(posedge CLK);
    #1;
    chk_outputs();
    bus.DataMemRead = 1'b0;
    RST             = 1'b1;
  endtask

  // One access cycle: drive, check combinational read data, cross the edge, check registered state.
  task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata_seen);
    bit          ok;
    bit          known;
    logic [31:0] exp_rd;
    bus.DataMemRead  = rd;
    bus.DataMemWrite = wr;
    bus.DataMemAddr  = addr;
    bus.DataMemWData = wdata;
    #2;
    ok     = m_ready && (addr < DEPTH);
    known  = 1'b1;
    exp_rd = 32'd0;
    if (rd && ok) begin
      if (m_mem.exists(int'(addr))) exp_rd = m_mem[int'(addr)];
      else known = CLEARS_MEM;
    end
    rdata_seen = bus.DataMemRData;
    if (known) chk("rdata", rdata_seen, exp_rd);
    @(posedge CLK);
    #1;
    if ((rd || wr) && !ok) begin
      if (!m_err) m_ea = addr;
      m_err = 1'b1;
    end else begin
      if (rd && m_rd < CMAX) m_rd++;
      if (wr) begin
        m_mem[int'(addr)] = wdata;
        if (m_wr < CMAX) m_wr++;
      end
    end
    m_edges++;
    m_ready = (m_edges >= READY_EDGES);
    chk_outputs();
    bus.DataMemRead  = 1'b0;
    bus.DataMemWrite = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] e_rdata;
    int unsigned e_rd;
    int unsigned e_wr;
    logic        e_err;
    logic [31:0] e_ea;
  } vec_t;

  vec_t        tbl [9];
  logic [31:0] rs;
  int unsigned base_rd;
  int unsigned base_wr;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'd16,   32'h2A, 32'h00, 0, 1, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b0, 32'd16,   32'h00, 32'h2A, 1, 1, 1'b0, 32'd0};
    tbl[2] = '{1'b0, 1'b1, 32'd32,   32'h07, 32'h00, 1, 2, 1'b0, 32'd0};
    tbl[3] = '{1'b1, 1'b1, 32'd32,   32'h09, 32'h07, 2, 3, 1'b0, 32'd0};
    tbl[4] = '{1'b1, 1'b0, 32'd32,   32'h00, 32'h09, 3, 3, 1'b0, 32'd0};
    tbl[5] = '{1'b0, 1'b1, 32'd1024, 32'h55, 32'h00, 3, 3, 1'b1, 32'd1024};
    tbl[6] = '{1'b0, 1'b1, 32'd2000, 32'h66, 32'h00, 3, 3, 1'b1, 32'd1024};
    tbl[7] = '{1'b1, 1'b0, 32'd1024, 32'h00, 32'h00, 4 - 1, 3, 1'b1, 32'd1024};
    tbl[8] = '{1'b1, 1'b0, 32'd16,   32'h00, 32'h2A, 4, 3, 1'b1, 32'd1024};

    bus.DataMemRead  = 1'b0;
    bus.DataMemWrite = 1'b0;
    bus.DataMemAddr  = 32'd0;
    bus.DataMemWData = 32'd0;
    #1;

`ifdef DMEM_CLEAR_EN
    do_reset();
    for (int e = 1; e <= 500; e++) step(1'b0, e == 10, 32'd3, 32'h5A, rs);
    chk("clear_err_flag", {31'd0, AccessErr}, 32'd1);
    chk("clear_err_addr", ErrAddr, 32'd3);
    chk("clear_wr_drop",  32'(WrCount), 32'd0);
    chk("clear_not_rdy",  {31'd0, MemReady}, 32'd0);
    do_reset();
    for (int e = 1; e <= int'(DEPTH); e++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0, rs);
      chk("ready_edge", {31'd0, MemReady}, 32'(e >= int'(DEPTH)));
    end
    step(1'b1, 1'b0, 32'd5, 32'd0, rs);
    chk("read5_cleared", rs, 32'd0);
    step(1'b1, 1'b0, 32'd3, 32'd0, rs);
    chk("read3_cleared", rs, 32'd0);
`else
    do_reset();
    step(1'b0, 1'b1, 32'd3, 32'h5A, rs);
    chk("first_err_flag", {31'd0, AccessErr}, 32'd1);
    chk("first_err_addr", ErrAddr, 32'd3);
    chk("first_wr_drop",  32'(WrCount), 32'd0);
    chk("first_ready",    {31'd0, MemReady}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 32'd0, rs);
    do_reset();
    step(1'b0, 1'b0, 32'd0, 32'd0, rs);
    chk("ready_after_1", {31'd0, MemReady}, 32'd1);
`endif

    base_rd = m_rd;
    base_wr = m_wr;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rs);
      chk($sformatf("tbl%0d_rdata", i), rs, tbl[i].e_rdata);
      chk($sformatf("tbl%0d_rdcnt", i), 32'(RdCount), base_rd + tbl[i].e_rd);
      chk($sformatf("tbl%0d_wrcnt", i), 32'(WrCount), base_wr + tbl[i].e_wr);
      chk($sformatf("tbl%0d_err", i),   {31'd0, AccessErr}, {31'd0, tbl[i].e_err});
      chk($sformatf("tbl%0d_eaddr", i), ErrAddr, tbl[i].e_ea);
    end

    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = DEPTH + $urandom_range(0, 5000);
      else if (sel == 1) a = $urandom | 32'h8000_0000;
      else               a = $urandom_range(0, 63);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, a, $urandom, rs);
    end
    chk("rd_saturated", 32'(RdCount), CMAX);
    chk("wr_saturated", 32'(WrCount), CMAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder for the RISCV core's data port. It is the memory end of the DataMemAddr/DataMemRead/DataMemWrite/DataMemRData/DataMemWData interface that the core drives. It provides word storage with a zero-latency read and a posted write on the clock edge. It also contains a post-reset clear sequencer, saturating access counters and sticky out-of-range error capture. It replaces bench-level behavioural memories in system tops and in FPGA builds.

## Interface
- DEPTH, 1024, number of 32-bit words; legal DataMemAddr range is 0..DEPTH-1 (word index, used directly, no byte shift)
- CNT_W, 32, width of the access counters
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  asynchronous, active-low reset
- DataMemAddr  in  32  word index of the access
- DataMemRead  in  1  read request, sampled combinationally
- DataMemWrite  in  1  write request, committed at the rising edge
- DataMemWData  in  32  write data
- DataMemRData  out  32  read data; reset value 0
- MemReady  out  1  memory accepts accesses; reset value 0
- AccessErr  out  1  sticky error flag; reset value 0
- ErrAddr  out  32  address of the first erroneous access; reset value 0
- RdCount  out  CNT_W  accepted reads; reset value 0
- WrCount  out  CNT_W  accepted writes; reset value 0

## Operation
- FSM states: CLEAR and READY. Reset forces CLEAR with ClrIdx=0.
- In CLEAR, each cycle writes 0 to word ClrIdx and then increments ClrIdx. The cycle that writes DEPTH-1 transitions to READY. MemReady=1 only in READY.
- In READY, a read returns the array word at DataMemAddr combinationally. DataMemRData=0 when DataMemRead=0.
- In READY, a write stores DataMemWData at the rising edge.
- Read and write asserted in the same cycle is legal:
  - RData shows the pre-write contents in that cycle.
  - The new value is visible from the next cycle.
  - Both counters increment.
- An access is in error if DataMemAddr >= DEPTH, or if it occurs while the FSM is in CLEAR.
  - An erroneous write is dropped.
  - An erroneous read returns 0.
  - Neither counter increments.
  - AccessErr is set.
  - ErrAddr is loaded only if AccessErr was 0 before the access, so it holds the first offender.
- Counters increment by 1 per accepted access and saturate at all-ones.
- AccessErr, ErrAddr and the counters are cleared only by reset.
- Array contents are not reset asynchronously; only the CLEAR sequence zeroes them.

## Timing
- Read latency 0 cycles (same cycle as DataMemAddr/DataMemRead).
- Write latency 1 edge; read-after-write to the same address in the following cycle returns the new data.
- MemReady rises exactly DEPTH rising edges after RST deasserts.
- Counters, AccessErr and ErrAddr update on the edge that samples the access.
- Reset asserted mid-CLEAR or mid-READY:
  - Immediately: MemReady=0 and all outputs return to their reset values.
  - The clear sequence restarts from 0 after release.
- System tops hold the core in reset until MemReady=1.

## Configuration
- DMEM_CLEAR_EN defined: the CLEAR state and sequencer are compiled in, and operation is as above.
- DMEM_CLEAR_EN undefined:
  - No CLEAR state; the FSM leaves reset directly in READY.
  - MemReady=0 only while RST is low and =1 from the first rising edge after release.
  - Array contents are uninitialised.
  - Accesses in that first post-release cycle are errors.

## Structure
- dmem_pkg holds:
  - the state enum (CLEAR, READY)
  - the DEPTH and CNT_W defaults
  - the address-range check function
- Sub-module dmem_array:
  - DEPTH x 32 storage
  - one synchronous write port and one asynchronous read port
  - the write port is muxed between the clear sequencer and the core
- Counters, error capture and FSM live in data_mem_resp.

## Test plan
- DMEM_CLEAR_EN on, DEPTH=1024, release RST at t0 -> MemReady=0 for 1024 edges, 1 after; read addr 5 then returns 0.
- Write 0x2A to addr 16, read addr 16 next cycle -> RData=0x2A, WrCount=1, RdCount=1, AccessErr=0.
- Addr 32 holds 7; same cycle read+write 9 to addr 32 -> RData=7 that cycle, 9 next cycle; both counters +1.
- Write 0x55 to addr 1024, then write to addr 2000 -> both dropped, AccessErr=1, ErrAddr=1024, WrCount unchanged; read addr 1024 returns 0.
- Write 0x11 to addr 3 at edge 10 after release (during CLEAR) -> dropped, AccessErr=1, ErrAddr=3; after MemReady, read addr 3 returns 0.
- Assert RST at edge 500 of CLEAR and release -> outputs at reset values, MemReady rises 1024 edges after second release, counters 0.
